root_dispatch: RTL



---
 rtl/root_dispatch.sv | 116 +++++++++++
 1 files changed

// File: rtl/root_dispatch.sv
// Request FIFO and single-outstanding issue controller in front of the root engine.
// Optional macro ROOT_DISPATCH_BYPASS_EN answers exponent-1 requests locally.
module root_dispatch #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_data_1,
    input  logic [2:0]  req_data_2,
    output logic        root_in_valid,
    output logic [9:0]  root_in_data_1,
    output logic [2:0]  root_in_data_2,
    input  logic        root_out_valid,
    input  logic [19:0] root_out_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [19:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GUARD} state_t;

    state_t      state;
    logic [9:0]  mem_rad [DEPTH];
    logic [2:0]  mem_exp [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        start;
    logic        local_one;
    logic [9:0]  head_rad;
    logic [2:0]  head_exp;

    always_comb begin
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty     = (wr_ptr == rd_ptr);
        req_ready = !full;
        push      = req_valid && !full;
        head_rad  = mem_rad[rd_ptr[AW-1:0]];
        head_exp  = mem_exp[rd_ptr[AW-1:0]];
        // The slot counts as free when it is being drained this very cycle.
        start     = (state == IDLE) && !empty && (!rsp_valid || rsp_ready);
`ifdef ROOT_DISPATCH_BYPASS_EN
        local_one = (head_exp == 3'd1);
`else
        local_one = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rad[wr_ptr[AW-1:0]] <= req_data_1;
            mem_exp[wr_ptr[AW-1:0]] <= req_data_2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            root_in_valid  <= 1'b0;
            root_in_data_1 <= '0;
            root_in_data_2 <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (start) rd_ptr <= rd_ptr + 1'b1;
            // Drain first; any load below overrides it in the same cycle.
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        if (head_exp == 3'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                        end else if (local_one) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= {head_rad, 10'b0};
                            rsp_err   <= 1'b0;
                        end else begin
                            root_in_data_1 <= head_rad;
                            root_in_data_2 <= head_exp;
                            root_in_valid  <= 1'b1;
                            state          <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    root_in_valid <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (root_out_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= root_out_data;
                        rsp_err   <= 1'b0;
                        state     <= GUARD;
                    end
                end
                GUARD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
